ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter sharing the `Multiport_Dynamic_ram` ports among `req_count` requesters (fetch, load/store, DMA).
- Accepts read/write requests on a valid/ready handshake and grants up to `port_count` per cycle.
- Drives the RAM port buses from registers and returns read data to the originating requester, tagged by requester index.
- Sits between the processor-side masters and the RAM instance.

## Interface
Parameters:
- `mem_width`, 12, RAM word width
- `addr_width`, 12, RAM address width
- `port_count`, 2, RAM ports driven
- `req_count`, 4, requesters (must be ≥ `port_count`)
- `read_latency`, 1, cycles from RAM address presented to `ram_dataout` valid

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  `req_count`  request pending, one bit per requester
- `req_write`  in  `req_count`  1 = write, 0 = read
- `req_addr`  in  `addr_width*req_count`  packed, requester i at `[i*addr_width +: addr_width]`
- `req_wdata`  in  `mem_width*req_count`  packed write data
- `req_ready`  out  `req_count`  request accepted this cycle (combinational)
- `rsp_valid`  out  `req_count`  read data valid, one-cycle pulse
- `rsp_rdata`  out  `mem_width*req_count`  packed read data
- `ram_address`  out  `addr_width*port_count`  to RAM `address`
- `ram_datain`  out  `mem_width*port_count`  to RAM `datain`
- `ram_mem_write`  out  `port_count`  to RAM `mem_write`
- `ram_dataout`  in  `mem_width*port_count`  from RAM `dataout`

## Operation
- A transfer occurs on requester i when `req_valid[i]` and `req_ready[i]` are both high in the same cycle.
- Requesters hold valid, write, addr and wdata stable until accepted.
- Grant scan:
  - Start at `rr_ptr` and go upward modulo `req_count`.
  - Grant up to `port_count` valid requesters.
  - The first grant takes port 0, the second port 1, and so on.
- Pointer update: after any grant, `rr_ptr` ← (last granted index + 1) mod `req_count`. With no grant, `rr_ptr` is unchanged.
- RAM-side registers latch the granted addr, wdata and write flag per port. On an unused port, `ram_mem_write`=0, `ram_address`=0 and `ram_datain`=0.
- Each port has a tag pipeline `{valid, is_read, req_idx}` of depth `read_latency`+1.
- When a read tag emerges, `ram_dataout` for that port is registered into slot `req_idx` of `rsp_rdata` and `rsp_valid[req_idx]` is pulsed.
- Writes produce no response.
- Two responses to the same requester cannot coincide: a requester gets at most one grant per cycle and latency is fixed.
- `rsp_rdata` slots hold their last value when `rsp_valid` is low.

## Timing
- Accept at cycle t.
- `ram_*` valid during cycle t+1.
- Read data at RAM during t+1+`read_latency`.
- `rsp_valid` high during t+2+`read_latency` (t+3 at default).
- Full throughput: `port_count` accepts per cycle, back-to-back, with no bubbles.
- Reset value of every output, and of `rr_ptr`, is 0.
- `req_ready` is forced to 0 while `reset` is high.
- Reset mid-operation clears the tag pipelines. In-flight reads are dropped and never produce `rsp_valid`. Writes already registered to the RAM in the reset cycle are suppressed (`ram_mem_write` is 0 the next cycle).
- When `rr_ptr` wraps from `req_count`-1 the scan continues at 0, preserving fairness: every continuously valid requester is granted within ⌈`req_count`/`port_count`⌉ cycles.

## Configuration
- `ARB_ADDR_CONFLICT_CHECK_EN` defined:
  - While scanning, a candidate is skipped if its address equals that of an already-granted request in the same cycle and either of the two is a write. A skipped candidate gets `req_ready`=0 and the scan continues past it.
  - `rr_ptr` update uses the last granted index only.
  - Read-read to the same address is allowed.
- `ARB_ADDR_CONFLICT_CHECK_EN` undefined:
  - No comparison is made; same-address accesses are issued on separate ports in the same cycle.
  - The write-write result is whatever the RAM produces and is not checked.

## Test plan
- Reset, then requester 0 writes addr 0x001 data 0x5F9 → `ram_mem_write`=01, `ram_address[11:0]`=0x001 at t+1. Requester 0 then reads 0x001 → `rsp_valid[0]` at t+3, `rsp_rdata[11:0]`=0x5F9.
- All 4 requesters valid for reads at addresses 0x004/0x008/0x00C/0x010:
  - cycle 1 grants 0,1; cycle 2 grants 2,3;
  - four `rsp_valid` pulses with the stored data.
- Requesters 0 and 1 both write addr 0x400 (0x111 and 0x222) with `ARB_ADDR_CONFLICT_CHECK_EN` defined:
  - requester 0 granted, requester 1 `req_ready`=0;
  - requester 1 is granted the following cycle and a later read of 0x400 returns 0x222.
- Requester 2 held valid continuously while requesters 0, 1 and 3 toggle → requester 2 granted at least once every 2 cycles, and `rr_ptr` wraps 3→0.
- Read accepted, then `reset` asserted one cycle later for one cycle → no `rsp_valid` for that read; all outputs 0; `rr_ptr`=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares the ports of a multiport RAM among several
// processor-side requesters (fetch, load/store, DMA). Up to port_count
// requests are accepted per cycle. The first grant of a cycle takes RAM
// port 0, the second takes port 1, and so on. The RAM port buses are driven
// from registers. Read data returns to the requester that issued the read.
//
// Optional feature (compile-time macro ARB_ADDR_CONFLICT_CHECK_EN):
//   When defined, a candidate whose address matches an already granted
//   request of the same cycle is skipped if either access is a write.
//   Read-read to the same address is still allowed.
//   When undefined, no address comparison is made.
//
// Parameters:
//   mem_width    RAM word width
//   addr_width   RAM address width
//   port_count   number of RAM ports driven
//   req_count    number of requesters (>= port_count)
//   read_latency cycles from address presented to ram_dataout valid
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   req_valid      request pending, one bit per requester
//   req_write      1 = write, 0 = read, per requester
//   req_addr       packed addresses, requester i at [i*addr_width +: addr_width]
//   req_wdata      packed write data, requester i at [i*mem_width +: mem_width]
//   req_ready      request accepted this cycle (combinational)
//   rsp_valid      read data valid, one-cycle pulse per requester
//   rsp_rdata      packed read data per requester, holds when not valid
//   ram_address    per-port RAM address (registered)
//   ram_datain     per-port RAM write data (registered)
//   ram_mem_write  per-port RAM write enable (registered)
//   ram_dataout    per-port RAM read data
// ============================================================================
module ram_port_arbiter #(
    parameter int mem_width    = 12,
    parameter int addr_width   = 12,
    parameter int port_count   = 2,
    parameter int req_count    = 4,
    parameter int read_latency = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [req_count-1:0]             req_valid,
    input  logic [req_count-1:0]             req_write,
    input  logic [addr_width*req_count-1:0]  req_addr,
    input  logic [mem_width*req_count-1:0]   req_wdata,
    output logic [req_count-1:0]             req_ready,
    output logic [req_count-1:0]             rsp_valid,
    output logic [mem_width*req_count-1:0]   rsp_rdata,
    output logic [addr_width*port_count-1:0] ram_address,
    output logic [mem_width*port_count-1:0]  ram_datain,
    output logic [port_count-1:0]            ram_mem_write,
    input  logic [mem_width*port_count-1:0]  ram_dataout
);

    // Width of a requester index and index of the last tag stage.
    localparam int IDX_W = (req_count > 1) ? $clog2(req_count) : 1;
    localparam int LAST  = read_latency;

    // ------------------------------------------------------------------
    // Grant scan results
    // ------------------------------------------------------------------
    logic [req_count-1:0]             grant_s;
    logic [port_count-1:0]            port_used_s;
    logic [port_count-1:0][IDX_W-1:0] port_idx_s;
    logic [IDX_W-1:0]                 last_s;
    logic                             hit_s;

    // Round-robin pointer
    logic [IDX_W-1:0]                 rr_ptr_q;
    logic [IDX_W-1:0]                 rr_ptr_d;

    // RAM-side port registers
    logic [port_count-1:0][addr_width-1:0] ram_addr_q;
    logic [port_count-1:0][addr_width-1:0] ram_addr_d;
    logic [port_count-1:0][mem_width-1:0]  ram_wdata_q;
    logic [port_count-1:0][mem_width-1:0]  ram_wdata_d;
    logic [port_count-1:0]                 ram_we_q;
    logic [port_count-1:0]                 ram_we_d;

    // Tag pipeline per port: stage 0 lines up with the RAM port registers,
    // stage LAST lines up with ram_dataout for that access.
    logic [LAST:0][port_count-1:0]            tag_vld_q;
    logic [LAST:0][port_count-1:0]            tag_vld_d;
    logic [LAST:0][port_count-1:0]            tag_rd_q;
    logic [LAST:0][port_count-1:0]            tag_rd_d;
    logic [LAST:0][port_count-1:0][IDX_W-1:0] tag_idx_q;
    logic [LAST:0][port_count-1:0][IDX_W-1:0] tag_idx_d;

    // Response registers
    logic [req_count-1:0]                rsp_valid_q;
    logic [req_count-1:0]                rsp_valid_d;
    logic [req_count-1:0][mem_width-1:0] rsp_rdata_q;
    logic [req_count-1:0][mem_width-1:0] rsp_rdata_d;

    // Round-robin scan from rr_ptr upward, filling RAM ports in grant order.
    always_comb begin
        logic [IDX_W:0]   sum_v;
        logic [IDX_W-1:0] idx_v;
        logic             conflict_v;
        logic             placed_v;

        grant_s     = '0;
        port_used_s = '0;
        port_idx_s  = '0;
        last_s      = rr_ptr_q;
        hit_s       = 1'b0;
        sum_v       = '0;
        idx_v       = '0;
        conflict_v  = 1'b0;
        placed_v    = 1'b0;

        for (int k = 0; k < req_count; k++) begin
            // Candidate index = (rr_ptr + k) mod req_count
            sum_v = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum_v >= (IDX_W+1)'(req_count)) begin
                sum_v = sum_v - (IDX_W+1)'(req_count);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[IDX_W-1:0];

`ifdef ARB_ADDR_CONFLICT_CHECK_EN
            // Same address as an earlier grant this cycle, and at least one
            // of the two is a write: skip this candidate for now.
            conflict_v = 1'b0;
            for (int p = 0; p < port_count; p++) begin
                if (port_used_s[p] &&
                    (req_addr[port_idx_s[p]*addr_width +: addr_width] ==
                     req_addr[idx_v*addr_width +: addr_width]) &&
                    (req_write[port_idx_s[p]] || req_write[idx_v])) begin
                    conflict_v = 1'b1;
                end else begin
                    conflict_v = conflict_v;
                end
            end
`else
            conflict_v = 1'b0;
`endif

            // A free port exists when not every port has been used yet.
            if (req_valid[idx_v] && !(&port_used_s) && !conflict_v) begin
                grant_s[idx_v] = 1'b1;
                last_s         = idx_v;
                hit_s          = 1'b1;
                placed_v       = 1'b0;
                // Take the lowest free port; ports fill strictly in order.
                for (int p = 0; p < port_count; p++) begin
                    if (!placed_v && !port_used_s[p]) begin
                        port_used_s[p] = 1'b1;
                        port_idx_s[p]  = idx_v;
                        placed_v       = 1'b1;
                    end else begin
                        placed_v = placed_v;
                    end
                end
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // No request is accepted while reset is asserted.
    assign req_ready = reset ? '0 : grant_s;

    // Pointer moves just past the last granted requester, wrapping to 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hit_s) begin
            if (last_s == IDX_W'(req_count - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = last_s + IDX_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Next RAM port values; unused ports are driven to all zeros.
    always_comb begin
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_we_d    = '0;
        for (int p = 0; p < port_count; p++) begin
            if (port_used_s[p]) begin
                ram_addr_d[p]  = req_addr[port_idx_s[p]*addr_width +: addr_width];
                ram_wdata_d[p] = req_wdata[port_idx_s[p]*mem_width +: mem_width];
                ram_we_d[p]    = req_write[port_idx_s[p]];
            end else begin
                ram_we_d[p]    = 1'b0;
            end
        end
    end

    // Tag pipeline advance: new tags enter at stage 0 and shift toward LAST.
    always_comb begin
        tag_vld_d = '0;
        tag_rd_d  = '0;
        tag_idx_d = '0;
        tag_vld_d[0] = port_used_s;
        tag_idx_d[0] = port_idx_s;
        for (int p = 0; p < port_count; p++) begin
            if (port_used_s[p]) begin
                tag_rd_d[0][p] = ~req_write[port_idx_s[p]];
            end else begin
                tag_rd_d[0][p] = 1'b0;
            end
        end
        for (int s = 1; s <= LAST; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_rd_d[s]  = tag_rd_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
    end

    // Route emerging read data to the slot of the requester that issued it.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        for (int p = 0; p < port_count; p++) begin
            if (tag_vld_q[LAST][p] && tag_rd_q[LAST][p]) begin
                rsp_valid_d[tag_idx_q[LAST][p]] = 1'b1;
                rsp_rdata_d[tag_idx_q[LAST][p]] = ram_dataout[p*mem_width +: mem_width];
            end else begin
                rsp_valid_d = rsp_valid_d;
            end
        end
    end

    // State registers; reset clears everything, dropping in-flight accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= '0;
            tag_vld_q   <= '0;
            tag_rd_q    <= '0;
            tag_idx_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            tag_vld_q   <= tag_vld_d;
            tag_rd_q    <= tag_rd_d;
            tag_idx_q   <= tag_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_address   = ram_addr_q;
    assign ram_datain    = ram_wdata_q;
    assign ram_mem_write = ram_we_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// tb_ram_port_arbiter
// ----------------------------------------------------------------------------
// Directed bench for ram_port_arbiter at default parameters. A per-cycle
// vector table drives the requesters and lists the expected ready pattern,
// RAM port outputs and responses for that cycle. A behavioural two-port RAM
// with one cycle of read latency sits on the RAM side. A hand-written
// sequence covers same-address accesses, with expectations chosen by
// ARB_ADDR_CONFLICT_CHECK_EN.
// ============================================================================
module tb_ram_port_arbiter;

    localparam int MW = 12;
    localparam int AW = 12;
    localparam int PC = 2;
    localparam int RC = 4;
    localparam int RL = 1;

    logic               clk;
    logic               reset;
    logic [RC-1:0]      req_valid;
    logic [RC-1:0]      req_write;
    logic [AW*RC-1:0]   req_addr;
    logic [MW*RC-1:0]   req_wdata;
    logic [RC-1:0]      req_ready;
    logic [RC-1:0]      rsp_valid;
    logic [MW*RC-1:0]   rsp_rdata;
    logic [AW*PC-1:0]   ram_address;
    logic [MW*PC-1:0]   ram_datain;
    logic [PC-1:0]      ram_mem_write;
    logic [MW*PC-1:0]   ram_dataout;

    ram_port_arbiter #(
        .mem_width   (MW),
        .addr_width  (AW),
        .port_count  (PC),
        .req_count   (RC),
        .read_latency(RL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .ram_address  (ram_address),
        .ram_datain   (ram_datain),
        .ram_mem_write(ram_mem_write),
        .ram_dataout  (ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural two-port RAM, registered read (latency 1), later port wins.
    logic [MW-1:0]         mem [0:4095];
    logic [PC-1:0][MW-1:0] dout_q;
    always @(posedge clk) begin
        for (int p = 0; p < PC; p++) begin
            dout_q[p] <= mem[ram_address[p*AW +: AW]];
            if (ram_mem_write[p]) begin
                mem[ram_address[p*AW +: AW]] <= ram_datain[p*MW +: MW];
            end
        end
    end
    assign ram_dataout = dout_q;

    typedef struct packed {
        logic             rst;
        logic [3:0]       vld;
        logic [3:0]       wr;
        logic [3:0][11:0] addr;
        logic [3:0][11:0] wdata;
        logic [3:0]       e_rdy;
        logic [1:0]       e_we;
        logic [1:0][11:0] e_addr;
        logic [3:0]       e_rspv;
        logic [3:0][11:0] e_rdata;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [0:NV-1];

    int n_pass;
    int n_total;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] w,
                                input logic [47:0] a, input logic [47:0] d,
                                input logic [3:0] er, input logic [1:0] ewe,
                                input logic [23:0] ea, input logic [3:0] erv,
                                input logic [47:0] erd);
        vec_t t;
        t.rst = r; t.vld = v; t.wr = w; t.addr = a; t.wdata = d;
        t.e_rdy = er; t.e_we = ewe; t.e_addr = ea; t.e_rspv = erv; t.e_rdata = erd;
        return t;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] w,
                         input logic [47:0] a, input logic [47:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [47:0] A0 = {12'h000, 12'h000, 12'h000, 12'h001};
    localparam logic [47:0] D0 = {12'h000, 12'h000, 12'h000, 12'h5F9};
    localparam logic [47:0] AQ = {12'h010, 12'h00C, 12'h008, 12'h004};
    localparam logic [47:0] DQ = {12'hD04, 12'hC03, 12'hB02, 12'hA01};
    localparam logic [47:0] AF = {12'h103, 12'h102, 12'h101, 12'h100};
    localparam logic [47:0] DF = {12'h333, 12'h222, 12'h111, 12'h0F0};
    localparam logic [47:0] R1 = {12'h000, 12'h000, 12'h000, 12'h5F9};
    localparam logic [47:0] RH = {12'h000, 12'h000, 12'hB02, 12'hA01};
    localparam logic [47:0] Z48 = 48'h0;

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        drive(4'b0000, 4'b0000, Z48, Z48);

        // rst  vld      wr       addr wdata  rdy      we     {p1,p0} addr            rspv     rdata
        // Reset: ready stays low even with every requester valid.
        vecs[0]  = mk(1'b1, 4'b1111, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b0000, Z48);
        // Requester 0 writes 0x5F9 to 0x001, then reads it back.
        vecs[1]  = mk(1'b0, 4'b0001, 4'b0001, A0, D0, 4'b0001, 2'b00, 24'h000000, 4'b0000, Z48);
        vecs[2]  = mk(1'b0, 4'b0000, 4'b0000, A0, D0, 4'b0000, 2'b01, 24'h000001, 4'b0000, Z48);
        vecs[3]  = mk(1'b0, 4'b0001, 4'b0000, A0, D0, 4'b0001, 2'b00, 24'h000000, 4'b0000, Z48);
        vecs[4]  = mk(1'b0, 4'b0000, 4'b0000, A0, D0, 4'b0000, 2'b00, 24'h000001, 4'b0000, Z48);
        vecs[5]  = mk(1'b0, 4'b0000, 4'b0000, A0, D0, 4'b0000, 2'b00, 24'h000000, 4'b0000, Z48);
        vecs[6]  = mk(1'b0, 4'b0000, 4'b0000, A0, D0, 4'b0000, 2'b00, 24'h000000, 4'b0001, R1);
        // Fill 0x004/0x008/0x00C/0x010; the last grant is requester 3, so rr_ptr wraps to 0.
        vecs[7]  = mk(1'b0, 4'b0001, 4'b0001, AQ, DQ, 4'b0001, 2'b00, 24'h000000, 4'b0000, R1);
        vecs[8]  = mk(1'b0, 4'b1110, 4'b1110, AQ, DQ, 4'b0110, 2'b01, 24'h000004, 4'b0000, R1);
        vecs[9]  = mk(1'b0, 4'b1000, 4'b1000, AQ, DQ, 4'b1000, 2'b11, 24'h00C008, 4'b0000, R1);
        // All four requesters read: grants 0,1 then 2,3, responses follow.
        vecs[10] = mk(1'b0, 4'b1111, 4'b0000, AQ, DQ, 4'b0011, 2'b01, 24'h000010, 4'b0000, R1);
        vecs[11] = mk(1'b0, 4'b1100, 4'b0000, AQ, DQ, 4'b1100, 2'b00, 24'h008004, 4'b0000, R1);
        vecs[12] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h01000C, 4'b0000, R1);
        vecs[13] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b0011, RH);
        vecs[14] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b1100, DQ);
        vecs[15] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b0000, DQ);
        // Requester 2 held valid while 0, 1, 3 toggle (writes to 0x10i).
        vecs[16] = mk(1'b0, 4'b0111, 4'b0111, AF, DF, 4'b0011, 2'b00, 24'h000000, 4'b0000, DQ);
        vecs[17] = mk(1'b0, 4'b1100, 4'b1100, AF, DF, 4'b1100, 2'b11, 24'h101100, 4'b0000, DQ);
        vecs[18] = mk(1'b0, 4'b0111, 4'b0111, AF, DF, 4'b0011, 2'b11, 24'h103102, 4'b0000, DQ);
        vecs[19] = mk(1'b0, 4'b1110, 4'b1110, AF, DF, 4'b1100, 2'b11, 24'h101100, 4'b0000, DQ);
        vecs[20] = mk(1'b0, 4'b1110, 4'b1110, AF, DF, 4'b0110, 2'b11, 24'h103102, 4'b0000, DQ);
        vecs[21] = mk(1'b0, 4'b1101, 4'b1101, AF, DF, 4'b1001, 2'b11, 24'h102101, 4'b0000, DQ);
        vecs[22] = mk(1'b0, 4'b0100, 4'b0100, AF, DF, 4'b0100, 2'b11, 24'h100103, 4'b0000, DQ);
        vecs[23] = mk(1'b0, 4'b0000, 4'b0000, AF, DF, 4'b0000, 2'b01, 24'h000102, 4'b0000, DQ);
        // Read accepted, reset next cycle: the read never responds.
        vecs[24] = mk(1'b0, 4'b0010, 4'b0000, AQ, DQ, 4'b0010, 2'b00, 24'h000000, 4'b0000, DQ);
        vecs[25] = mk(1'b1, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000008, 4'b0000, DQ);
        vecs[26] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b0000, Z48);
        vecs[27] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b0000, Z48);
        // rr_ptr back at 0 after reset: grants 0,1 first.
        vecs[28] = mk(1'b0, 4'b1111, 4'b0000, AQ, DQ, 4'b0011, 2'b00, 24'h000000, 4'b0000, Z48);
        vecs[29] = mk(1'b0, 4'b1100, 4'b0000, AQ, DQ, 4'b1100, 2'b00, 24'h008004, 4'b0000, Z48);
        vecs[30] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h01000C, 4'b0000, Z48);
        vecs[31] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b0011, RH);
        vecs[32] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b1100, DQ);
        vecs[33] = mk(1'b0, 4'b0000, 4'b0000, AQ, DQ, 4'b0000, 2'b00, 24'h000000, 4'b0000, DQ);

        step();
        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("v%0d ready", i),     64'(req_ready),     64'(vecs[i].e_rdy));
            check($sformatf("v%0d mem_write", i), 64'(ram_mem_write), 64'(vecs[i].e_we));
            check($sformatf("v%0d address", i),   64'(ram_address),   64'(vecs[i].e_addr));
            check($sformatf("v%0d rsp_valid", i), 64'(rsp_valid),     64'(vecs[i].e_rspv));
            check($sformatf("v%0d rsp_rdata", i), 64'(rsp_rdata),     64'(vecs[i].e_rdata));
            step();
        end
        reset = 1'b0;

        // Same-address sequence, rr_ptr = 0 here.
        drive(4'b0011, 4'b0011, {12'h000, 12'h000, 12'h400, 12'h400},
              {12'h000, 12'h000, 12'h222, 12'h111});
        #1;
`ifdef ARB_ADDR_CONFLICT_CHECK_EN
        check("ww ready", 64'(req_ready), 64'(4'b0001));
`else
        check("ww ready", 64'(req_ready), 64'(4'b0011));
`endif
        step();
        drive(4'b0010, 4'b0010, {12'h000, 12'h000, 12'h400, 12'h400},
              {12'h000, 12'h000, 12'h222, 12'h111});
        #1;
        check("ww2 ready", 64'(req_ready), 64'(4'b0010));
`ifdef ARB_ADDR_CONFLICT_CHECK_EN
        check("ww mem_write", 64'(ram_mem_write), 64'(2'b01));
        check("ww address",   64'(ram_address),   64'(24'h000400));
        check("ww datain",    64'(ram_datain),    64'(24'h000111));
`else
        check("ww mem_write", 64'(ram_mem_write), 64'(2'b11));
        check("ww address",   64'(ram_address),   64'(24'h400400));
        check("ww datain",    64'(ram_datain),    64'(24'h222111));
`endif
        step();
        drive(4'b1100, 4'b0000, {12'h400, 12'h400, 12'h000, 12'h000}, Z48);
        #1;
        check("rr ready",      64'(req_ready),     64'(4'b1100));
        check("ww2 mem_write", 64'(ram_mem_write), 64'(2'b01));
        check("ww2 datain",    64'(ram_datain),    64'(24'h000222));
        step();
        drive(4'b0000, 4'b0000, Z48, Z48);
        #1;
        check("rr address",   64'(ram_address),   64'(24'h400400));
        check("rr mem_write", 64'(ram_mem_write), 64'(2'b00));
        step();
        check("rr early", 64'(rsp_valid), 64'(4'b0000));
        step();
        check("rr rsp_valid", 64'(rsp_valid),       64'(4'b1100));
        check("rr rsp_rdata", 64'(rsp_rdata[47:24]), 64'(24'h222222));
        step();
        check("rr rsp end", 64'(rsp_valid), 64'(4'b0000));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
